// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared slot-state and requester-id types for the arbitrated adder.
`default_nettype none

package adder_arb_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   function automatic req_id_e other_req(input req_id_e id);
      return (id == REQ0) ? REQ1 : REQ0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_arb_if.sv
// adder_arb_if: two-requester operand/response handshake bundle for adder_arb.
`default_nettype none

interface adder_arb_if #(
   parameter int WIDTH = 32
);
   logic             i_req0_valid;
   logic             i_req1_valid;
   logic             o_req0_ready;
   logic             o_req1_ready;
   logic [WIDTH-1:0] i_req0_a;
   logic [WIDTH-1:0] i_req0_b;
   logic [WIDTH-1:0] i_req1_a;
   logic [WIDTH-1:0] i_req1_b;
   logic             o_rsp0_valid;
   logic             o_rsp1_valid;
   logic             i_rsp0_ready;
   logic             i_rsp1_ready;
   logic [WIDTH-1:0] o_rsp_sum;

   modport slave (
      input  i_req0_valid, i_req1_valid,
      output o_req0_ready, o_req1_ready,
      input  i_req0_a, i_req0_b, i_req1_a, i_req1_b,
      output o_rsp0_valid, o_rsp1_valid,
      input  i_rsp0_ready, i_rsp1_ready,
      output o_rsp_sum
   );

   modport master (
      output i_req0_valid, i_req1_valid,
      input  o_req0_ready, o_req1_ready,
      output i_req0_a, i_req0_b, i_req1_a, i_req1_b,
      input  o_rsp0_valid, o_rsp1_valid,
      output i_rsp0_ready, i_rsp1_ready,
      input  o_rsp_sum
   );

endinterface

`default_nettype wire

// File: rtl/adder_arb_csadd.sv
// adder_arb_csadd: carry-select adder; upper half precomputed for both carry-ins, carry-out dropped.
`default_nettype none

module adder_arb_csadd #(
   parameter int WIDTH = 32
) (
   input  wire logic [WIDTH-1:0] a_i,
   input  wire logic [WIDTH-1:0] b_i,
   output logic      [WIDTH-1:0] sum_o
);

   localparam int HALF = WIDTH / 2;

   logic [HALF:0]   lo_w;
   logic [HALF-1:0] hi0_w;
   logic [HALF-1:0] hi1_w;

   assign lo_w  = {1'b0, a_i[HALF-1:0]} + {1'b0, b_i[HALF-1:0]};
   assign hi0_w = a_i[WIDTH-1:HALF] + b_i[WIDTH-1:HALF];
   assign hi1_w = a_i[WIDTH-1:HALF] + b_i[WIDTH-1:HALF] + HALF'(1);

   assign sum_o = {(lo_w[HALF] ? hi1_w : hi0_w), lo_w[HALF-1:0]};

endmodule

`default_nettype wire

// File: rtl/adder_arb.sv
// adder_arb: one shared adder time-multiplexed between two round-robin requesters,
// with a single registered result slot that can drain and refill in the same cycle.
`default_nettype none

module adder_arb
   import adder_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input wire logic   i_clk,
   input wire logic   i_reset_n,
   adder_arb_if.slave bus
);

   state_e           state_q, state_d;
   req_id_e          owner_q, owner_d;
   req_id_e          last_q, last_d;
   logic [WIDTH-1:0] sum_q, sum_d;

   req_id_e          grant_w;
   logic             any_w;
   logic             drain_w;
   logic             free_w;
   logic             ready0_w;
   logic             ready1_w;
   logic             accept_w;
   logic [WIDTH-1:0] op_a_w;
   logic [WIDTH-1:0] op_b_w;
   logic [WIDTH-1:0] add_w;

   always_comb begin
      grant_w = REQ0;
      if (bus.i_req1_valid && !bus.i_req0_valid) begin
         grant_w = REQ1;
      end else if (bus.i_req0_valid && bus.i_req1_valid) begin
         grant_w = other_req(last_q);
      end
   end

   assign any_w   = bus.i_req0_valid | bus.i_req1_valid;
   // Only the owner's ready can drain the slot; the other response ready is ignored.
   assign drain_w = (state_q == ST_FULL) &&
                    ((owner_q == REQ0) ? bus.i_rsp0_ready : bus.i_rsp1_ready);
   assign free_w  = (state_q == ST_EMPTY) || drain_w;

   assign ready0_w = i_reset_n && free_w && bus.i_req0_valid && (grant_w == REQ0);
   assign ready1_w = i_reset_n && free_w && bus.i_req1_valid && (grant_w == REQ1);
   assign accept_w = any_w && (ready0_w || ready1_w);

   assign op_a_w = (grant_w == REQ0) ? bus.i_req0_a : bus.i_req1_a;
   assign op_b_w = (grant_w == REQ0) ? bus.i_req0_b : bus.i_req1_b;

   adder_arb_csadd #(
      .WIDTH (WIDTH)
   ) u_add (
      .a_i   (op_a_w),
      .b_i   (op_b_w),
      .sum_o (add_w)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      sum_d   = sum_q;
      if (accept_w) begin
         state_d = ST_FULL;
         owner_d = grant_w;
         last_d  = grant_w;
         sum_d   = add_w;
      end else if (drain_w) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_EMPTY;
         owner_q <= REQ0;
         last_q  <= REQ1;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         sum_q   <= sum_d;
      end
   end

   assign bus.o_req0_ready = ready0_w;
   assign bus.o_req1_ready = ready1_w;
   assign bus.o_rsp0_valid = (state_q == ST_FULL) && (owner_q == REQ0);
   assign bus.o_rsp1_valid = (state_q == ST_FULL) && (owner_q == REQ1);
   assign bus.o_rsp_sum    = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_arb.sv
// tb_adder_arb: directed vectors with hand-computed sums for adder_arb.
`default_nettype none

module tb_adder_arb;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   adder_arb_if #(.WIDTH(32)) bus ();

   adder_arb #(
      .WIDTH (32)
   ) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ready(input string tag, input logic r0, input logic r1);
      check_val({tag, "_ready0"}, 32'(bus.o_req0_ready), 32'(r0));
      check_val({tag, "_ready1"}, 32'(bus.o_req1_ready), 32'(r1));
   endtask

   task automatic check_rsp(input string tag, input logic v0, input logic v1, input logic [31:0] s);
      check_val({tag, "_rsp0v"}, 32'(bus.o_rsp0_valid), 32'(v0));
      check_val({tag, "_rsp1v"}, 32'(bus.o_rsp1_valid), 32'(v1));
      check_val({tag, "_sum"}, bus.o_rsp_sum, s);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n            = 1'b0;
      bus.i_req0_valid = 1'b1;
      bus.i_req1_valid = 1'b1;
      bus.i_req0_a     = 32'd0;
      bus.i_req0_b     = 32'd0;
      bus.i_req1_a     = 32'd0;
      bus.i_req1_b     = 32'd0;
      bus.i_rsp0_ready = 1'b1;
      bus.i_rsp1_ready = 1'b1;

      // Reset state; readies must stay low even with requests offered.
      #12;
      check_rsp("reset", 1'b0, 1'b0, 32'h0);
      check_ready("reset", 1'b0, 1'b0);
      bus.i_req0_valid = 1'b0;
      bus.i_req1_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_ready("idle", 1'b0, 1'b0);

      // Single request, latency 1.
      bus.i_req0_valid = 1'b1;
      bus.i_req0_a = 32'h0000_0005;
      bus.i_req0_b = 32'h0000_0003;
      #1;
      check_ready("single", 1'b1, 1'b0);
      tick();
      bus.i_req0_valid = 1'b0;
      check_rsp("single", 1'b1, 1'b0, 32'h0000_0008);
      tick();
      check_rsp("single_drained", 1'b0, 1'b0, 32'h0000_0008);

      // Wrap-around sums, second one refilling while the first drains.
      bus.i_req1_valid = 1'b1;
      bus.i_req1_a = 32'hFFFF_FFFF;
      bus.i_req1_b = 32'h0000_0001;
      #1;
      check_ready("wrap1", 1'b0, 1'b1);
      tick();
      check_rsp("wrap1", 1'b0, 1'b1, 32'h0000_0000);
      bus.i_req1_a = 32'h8000_0000;
      bus.i_req1_b = 32'h8000_0000;
      bus.i_req0_a = 32'h7FFF_FFFF;
      #1;
      check_ready("wrap2", 1'b0, 1'b1);
      tick();
      check_rsp("wrap2", 1'b0, 1'b1, 32'h0000_0000);
      bus.i_req1_valid = 1'b0;
      tick();

      // Tie: alternate 0,1,0,1 at one accept per cycle.
      bus.i_req0_valid = 1'b1;
      bus.i_req1_valid = 1'b1;
      bus.i_req0_a = 32'd1;
      bus.i_req0_b = 32'd1;
      bus.i_req1_a = 32'd2;
      bus.i_req1_b = 32'd2;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_ready($sformatf("tie%0d", k), (k % 2) == 0, (k % 2) == 1);
         tick();
         check_rsp($sformatf("tie%0d", k), (k % 2) == 0, (k % 2) == 1,
                   ((k % 2) == 0) ? 32'd2 : 32'd4);
      end
      bus.i_req1_valid = 1'b0;

      // Backpressure: req0 result held, req1 waits.
      bus.i_req0_a = 32'd10;
      bus.i_req0_b = 32'd20;
      bus.i_rsp0_ready = 1'b0;
      #1;
      check_ready("bp_load", 1'b1, 1'b0);
      tick();
      bus.i_req0_valid = 1'b0;
      bus.i_req1_valid = 1'b1;
      bus.i_req1_a = 32'd7;
      bus.i_req1_b = 32'd9;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_ready($sformatf("bp%0d", k), 1'b0, 1'b0);
         check_rsp($sformatf("bp%0d", k), 1'b1, 1'b0, 32'd30);
         tick();
      end
      bus.i_rsp0_ready = 1'b1;
      #1;
      check_ready("bp_release", 1'b0, 1'b1);
      tick();
      bus.i_req1_valid = 1'b0;
      check_rsp("bp_release", 1'b0, 1'b1, 32'd16);

      // Non-owner ready must not drain the slot.
      bus.i_rsp1_ready = 1'b0;
      bus.i_req0_valid = 1'b1;
      #1;
      check_ready("nonowner", 1'b0, 1'b0);
      tick();
      tick();
      check_rsp("nonowner", 1'b0, 1'b1, 32'd16);

      // Load 0x1234_5678 for req0 via pass-through, then reset mid-operation.
      bus.i_req0_a = 32'h1234_0000;
      bus.i_req0_b = 32'h0000_5678;
      bus.i_rsp1_ready = 1'b1;
      bus.i_rsp0_ready = 1'b0;
      #1;
      check_ready("rst_load", 1'b1, 1'b0);
      tick();
      bus.i_req0_valid = 1'b0;
      check_rsp("rst_load", 1'b1, 1'b0, 32'h1234_5678);
      #2;
      rst_n = 1'b0;
      bus.i_req0_valid = 1'b1;
      bus.i_req1_valid = 1'b1;
      bus.i_req0_a = 32'd1;
      bus.i_req0_b = 32'd1;
      bus.i_req1_a = 32'd2;
      bus.i_req1_b = 32'd2;
      bus.i_rsp0_ready = 1'b1;
      #1;
      check_rsp("midrst", 1'b0, 1'b0, 32'h0);
      check_ready("midrst", 1'b0, 1'b0);
      tick();
      #2;
      rst_n = 1'b1;
      #1;
      check_ready("post_rst", 1'b1, 1'b0);
      tick();
      check_rsp("post_rst", 1'b1, 1'b0, 32'd2);
      bus.i_req0_valid = 1'b0;
      bus.i_req1_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
